uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
- Downstream consumer of the UART receiver's byte stream (read_data/read_valid/read_ready).
- Delimits framed command packets, checks length and checksum, and buffers the payload internally.
- Releases a payload to the command/control logic only after the whole frame has validated.
- Drops malformed or stalled frames and re-synchronises on the next start-of-frame byte.

Parameters:
- DATA_WIDTH, 8, byte width of input and output streams.
- MAX_PAYLOAD, 16, maximum payload bytes per frame; LEN_W = $clog2(MAX_PAYLOAD+1).
- SOF_BYTE, 8'hA5, start-of-frame delimiter.
- TIMEOUT_CYCLES, 12000, max clk cycles between accepted bytes inside a frame (1 ms at 12 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  DATA_WIDTH  byte from UART rx.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts byte this cycle.
- out_data  out  DATA_WIDTH  validated payload byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_last  out  1  final payload byte of frame.
- out_len  out  LEN_W  payload length of the frame being drained.
- frame_ok  out  1  one-cycle pulse: frame validated.
- err_len  out  1  one-cycle pulse: LEN is 0 or greater than MAX_PAYLOAD.
- err_chk  out  1  one-cycle pulse: checksum mismatch.
- err_timeout  out  1  one-cycle pulse: inter-byte timeout.

Behaviour:
- Frame format: SOF, LEN, LEN payload bytes, CHK.
  - CHK = XOR of LEN and all payload bytes.
- Input handshake: a byte is accepted when in_valid && in_ready.
  - in_ready = 1 in HUNT, LEN, PAYLOAD, CHK.
  - in_ready = 0 in DRAIN and while rst_n = 0.
- Reset:
  - State goes to HUNT.
  - All outputs 0 (out_data, out_len = 0).
  - Buffer contents are don't-care.
  - Reset mid-frame or mid-drain discards everything; no error pulse.
- State machine:
  - HUNT: accepted SOF_BYTE goes to LEN; any other byte is silently dropped.
  - LEN: accepted byte L.
    - L == 0 or L > MAX_PAYLOAD: pulse err_len, go to HUNT.
    - Otherwise store len = L, checksum = L, idx = 0, go to PAYLOAD.
  - PAYLOAD: each accepted byte is written to buf[idx], checksum ^= byte, idx++.
    - After byte idx == len-1, go to CHK.
    - SOF_BYTE inside the payload is ordinary data.
  - CHK: accepted byte compared with the checksum.
    - Match: pulse frame_ok, load out_len = len, idx = 0, go to DRAIN.
    - Mismatch: pulse err_chk, go to HUNT.
  - DRAIN: out_valid = 1, out_data = buf[idx], out_last = (idx == len-1).
    - On out_valid && out_ready, idx++.
    - Handshake on the last byte: out_valid drops next cycle, go to HUNT.
- Output latency: out_valid rises the cycle after the CHK byte is accepted (same cycle frame_ok is high).
  - out_data, out_last and out_len are held stable while out_valid && !out_ready.
- Timeout:
  - Counter clears on every accepted byte and on entry to LEN.
  - It increments each cycle in LEN, PAYLOAD, CHK.
  - When it reaches TIMEOUT_CYCLES-1 with no byte accepted: pulse err_timeout, go to HUNT.
  - If a byte is accepted in the expiry cycle, the byte wins and there is no timeout.
  - No timeout in HUNT or DRAIN.
- Error pulses are mutually exclusive, last exactly one cycle, and are registered outputs.
- Backpressure: no bytes are accepted during DRAIN; the upstream UART holds its byte (read_valid high) until DRAIN ends.
- Buffer: MAX_PAYLOAD x DATA_WIDTH registers; len and idx are LEN_W bits with no wrap past len-1.

Test Plan:
- Valid frame: A5 03 11 22 33 03, out_ready = 1 -> frame_ok pulse; out_data 11, 22, 33 on consecutive cycles; out_last only on 33; out_len = 3; no error pulses.
- Bad checksum: A5 02 10 20 31 -> err_chk pulse one cycle after 31; no out_valid; following A5 01 7E 7F -> out_data 7E with out_last.
- Length errors: A5 00 -> err_len. A5 with LEN = MAX_PAYLOAD+1 (0x11) -> err_len, state HUNT. MAX_PAYLOAD frame of 16 bytes 00..0F with correct CHK -> all 16 delivered in order.
- Junk and resync: 00 FF 55 A5 01 A5 A4 -> the three junk bytes dropped; out_data A5 (in-payload SOF treated as data), out_last = 1.
- Backpressure and timeout:
  - Valid 3-byte frame with out_ready toggling 1,0,0,1,... -> out_data stable while stalled; in_ready = 0 throughout DRAIN.
  - A5 02 11 then idle for TIMEOUT_CYCLES -> err_timeout pulse, state HUNT.
  - Byte arriving exactly in the expiry cycle -> accepted, no timeout.
- Reset mid-operation: assert rst_n = 0 for one cycle during PAYLOAD and again during DRAIN -> all outputs 0 next cycle, no error pulses; next valid frame is received correctly.

Source files
------------

// File: rtl/uart_frame_rx.sv
// Frame receiver for the UART byte stream: delimits SOF/LEN/payload/CHK packets,
// buffers the payload and replays it downstream only after the checksum matches.
module uart_frame_rx #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    MAX_PAYLOAD    = 16,
    parameter logic [DATA_WIDTH-1:0] SOF_BYTE       = 8'hA5,
    parameter int                    TIMEOUT_CYCLES = 12000,
    parameter int                    LEN_W          = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [LEN_W-1:0]      out_len,
    output logic                  frame_ok,
    output logic                  err_len,
    output logic                  err_chk,
    output logic                  err_timeout
);
    localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] LEN_MAX  = DATA_WIDTH'(MAX_PAYLOAD);
    localparam logic [LEN_W-1:0]      LEN_ONE  = LEN_W'(1);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] chk_update(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] b
    );
        return acc ^ b;
    endfunction

    state_t                  state_r, state_nxt_s;
    logic                    in_ready_r;
    logic                    accept_s, in_frame_s, timeout_s;
    logic                    len_bad_s, len_good_s, pay_wr_s, chk_ok_s, chk_bad_s;
    logic                    drain_hs_s, drain_end_s;
    logic [LEN_W-1:0]        len_r, idx_r, idx_inc_s;
    logic [DATA_WIDTH-1:0]   chk_r;
    logic [TMR_W-1:0]        tmr_r;
    logic [DATA_WIDTH-1:0]   buf_r [MAX_PAYLOAD];
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic                    out_valid_r, out_last_r;
    logic [LEN_W-1:0]        out_len_r;
    logic                    frame_ok_r, err_len_r, err_chk_r, err_timeout_r;

    // in_ready is forced low while reset is held, independent of the stored state
    assign in_ready    = rst_n & in_ready_r;
    assign accept_s    = in_valid & in_ready;
    assign idx_inc_s   = idx_r + LEN_ONE;
    assign drain_hs_s  = out_valid_r & out_ready;

    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;
    assign out_last    = out_last_r;
    assign out_len     = out_len_r;
    assign frame_ok    = frame_ok_r;
    assign err_len     = err_len_r;
    assign err_chk     = err_chk_r;
    assign err_timeout = err_timeout_r;

    // Next-state and per-cycle event strobes
    always_comb begin
        state_nxt_s = state_r;
        len_bad_s   = 1'b0;
        len_good_s  = 1'b0;
        pay_wr_s    = 1'b0;
        chk_ok_s    = 1'b0;
        chk_bad_s   = 1'b0;
        drain_end_s = 1'b0;
        in_frame_s  = (state_r == S_LEN) || (state_r == S_PAYLOAD) || (state_r == S_CHK);
        timeout_s   = in_frame_s && !accept_s && (tmr_r == TMR_LAST);
        case (state_r)
            S_HUNT: begin
                if (accept_s && (in_data == SOF_BYTE)) state_nxt_s = S_LEN;
                else                                   state_nxt_s = S_HUNT;
            end
            S_LEN: begin
                if (accept_s) begin
                    if ((in_data == {DATA_WIDTH{1'b0}}) || (in_data > LEN_MAX)) begin
                        len_bad_s   = 1'b1;
                        state_nxt_s = S_HUNT;
                    end else begin
                        len_good_s  = 1'b1;
                        state_nxt_s = S_PAYLOAD;
                    end
                end else if (timeout_s) begin
                    state_nxt_s = S_HUNT;
                end else begin
                    state_nxt_s = S_LEN;
                end
            end
            S_PAYLOAD: begin
                if (accept_s) begin
                    pay_wr_s = 1'b1;
                    if (idx_r == (len_r - LEN_ONE)) state_nxt_s = S_CHK;
                    else                            state_nxt_s = S_PAYLOAD;
                end else if (timeout_s) begin
                    state_nxt_s = S_HUNT;
                end else begin
                    state_nxt_s = S_PAYLOAD;
                end
            end
            S_CHK: begin
                if (accept_s) begin
                    if (in_data == chk_r) begin
                        chk_ok_s    = 1'b1;
                        state_nxt_s = S_DRAIN;
                    end else begin
                        chk_bad_s   = 1'b1;
                        state_nxt_s = S_HUNT;
                    end
                end else if (timeout_s) begin
                    state_nxt_s = S_HUNT;
                end else begin
                    state_nxt_s = S_CHK;
                end
            end
            S_DRAIN: begin
                if (drain_hs_s && out_last_r) begin
                    drain_end_s = 1'b1;
                    state_nxt_s = S_HUNT;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: state_nxt_s = S_HUNT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= S_HUNT;
        else        state_r <= state_nxt_s;
    end

    // Frame bookkeeping: length, index, running checksum, inter-byte timer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r <= 1'b1;
            len_r      <= {LEN_W{1'b0}};
            idx_r      <= {LEN_W{1'b0}};
            chk_r      <= {DATA_WIDTH{1'b0}};
            tmr_r      <= {TMR_W{1'b0}};
        end else begin
            in_ready_r <= (state_nxt_s != S_DRAIN);
            if (accept_s || timeout_s || !in_frame_s) tmr_r <= {TMR_W{1'b0}};
            else                                      tmr_r <= tmr_r + TMR_W'(1);
            if (len_good_s) begin
                len_r <= LEN_W'(in_data);
                chk_r <= in_data;
                idx_r <= {LEN_W{1'b0}};
            end else if (pay_wr_s) begin
                chk_r <= chk_update(chk_r, in_data);
                // idx parks on len-1 rather than wrapping
                if (idx_r != (len_r - LEN_ONE)) idx_r <= idx_inc_s;
            end else if (chk_ok_s) begin
                idx_r <= {LEN_W{1'b0}};
            end else if (drain_hs_s && !drain_end_s) begin
                idx_r <= idx_inc_s;
            end
        end
    end

    // Payload buffer; contents only matter between a write and its drain
    always_ff @(posedge clk) begin
        if (pay_wr_s) buf_r[idx_r[IDX_W-1:0]] <= in_data;
    end

    // Registered output stream and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r    <= {DATA_WIDTH{1'b0}};
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_len_r     <= {LEN_W{1'b0}};
            frame_ok_r    <= 1'b0;
            err_len_r     <= 1'b0;
            err_chk_r     <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            frame_ok_r    <= chk_ok_s;
            err_len_r     <= len_bad_s;
            err_chk_r     <= chk_bad_s;
            err_timeout_r <= timeout_s;
            if (chk_ok_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= buf_r[0];
                out_last_r  <= (len_r == LEN_ONE);
                out_len_r   <= len_r;
            end else if (drain_end_s) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end else if (drain_hs_s) begin
                out_data_r  <= buf_r[idx_inc_s[IDX_W-1:0]];
                out_last_r  <= (idx_inc_s == (len_r - LEN_ONE));
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed vector table, hand-written
// timeout/reset sequences, and random streams against a frame-level parser model.
module tb_uart_frame_rx;
    localparam int T      = 40;
    localparam int EV_OK  = 1;
    localparam int EV_LEN = 2;
    localparam int EV_CHK = 3;
    localparam int EV_TMO = 4;

    logic       clk, rst_n;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_last;
    logic [4:0] out_len;
    logic       frame_ok, err_len, err_chk, err_timeout;

    int tests, failed, cyc, rdy_mode;
    logic [7:0] stim_q[$];
    int         exp_evt[$], got_evt[$], got_evt_cyc[$];
    logic [7:0] exp_data[$], got_data[$];
    logic       exp_last[$], got_last[$];
    int         exp_len[$], got_len[$], got_cyc[$];

    typedef struct {
        logic [191:0] bytes;
        int           nb;
        int           ev;
        logic [127:0] pay;
        int           np;
        int           mode;
    } vec_t;
    vec_t tbl[8];

    uart_frame_rx #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_len(out_len),
        .frame_ok(frame_ok), .err_len(err_len), .err_chk(err_chk), .err_timeout(err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return {13'd0, out_valid, out_last, frame_ok, err_len, err_chk, err_timeout, out_data, out_len};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            tests++;
            failed++;
            $display("FAIL send_wait: in_ready stayed low for %0d cycles, required high", n);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drive_stim(input int max_gap);
        foreach (stim_q[k]) begin
            repeat ($urandom_range(0, max_gap)) tick();
            send_byte(stim_q[k]);
        end
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (out_valid && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            tests++;
            failed++;
            $display("FAIL drain_wait: out_valid stayed high for %0d cycles, required low", n);
        end
        repeat (T + 10) tick();
    endtask

    task automatic expect_ok(input logic [7:0] p[$]);
        exp_evt.push_back(EV_OK);
        foreach (p[k]) begin
            exp_data.push_back(p[k]);
            exp_last.push_back(k == p.size() - 1);
            exp_len.push_back(p.size());
        end
    endtask

    // Frame-level reference: parse the byte list with the frame rules; a frame
    // left open when the stream ends is expected to time out.
    task automatic model_stream();
        int i, n, L;
        logic [7:0] x;
        logic [7:0] p[$];
        i = 0;
        n = stim_q.size();
        while (i < n) begin
            if (stim_q[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            if (i >= n) begin
                exp_evt.push_back(EV_TMO);
                break;
            end
            L = int'(stim_q[i]);
            i++;
            if (L == 0 || L > 16) begin
                exp_evt.push_back(EV_LEN);
                continue;
            end
            if (i + L >= n) begin
                exp_evt.push_back(EV_TMO);
                break;
            end
            x = 8'(L);
            p.delete();
            for (int k = 0; k < L; k++) begin
                x = x ^ stim_q[i + k];
                p.push_back(stim_q[i + k]);
            end
            if (stim_q[i + L] == x) expect_ok(p);
            else                    exp_evt.push_back(EV_CHK);
            i += L + 1;
        end
    endtask

    task automatic gen_stream();
        int nf, kind, L, k;
        logic [7:0] x, b;
        nf = $urandom_range(1, 5);
        for (int f = 0; f < nf; f++) begin
            kind = $urandom_range(0, 5);
            if (kind <= 3) begin
                L = $urandom_range(1, 16);
                stim_q.push_back(8'hA5);
                stim_q.push_back(8'(L));
                x = 8'(L);
                for (int j = 0; j < L; j++) begin
                    b = 8'($urandom_range(0, 255));
                    stim_q.push_back(b);
                    x = x ^ b;
                end
                if (kind == 3) x = x ^ 8'($urandom_range(1, 255));
                stim_q.push_back(x);
            end else if (kind == 4) begin
                stim_q.push_back(8'hA5);
                if ($urandom_range(0, 1) == 0) stim_q.push_back(8'h00);
                else                           stim_q.push_back(8'($urandom_range(17, 255)));
            end else begin
                repeat ($urandom_range(1, 3)) begin
                    b = 8'($urandom_range(0, 255));
                    stim_q.push_back((b == 8'hA5) ? 8'h00 : b);
                end
            end
        end
        if ($urandom_range(0, 3) == 0) begin
            stim_q.push_back(8'hA5);
            if ($urandom_range(0, 3) != 0) begin
                L = $urandom_range(1, 16);
                stim_q.push_back(8'(L));
                k = $urandom_range(0, L);
                repeat (k) stim_q.push_back(8'($urandom_range(0, 255)));
            end
        end
    endtask

    task automatic compare(input string name, input logic timing);
        check($sformatf("%s_nevt", name), got_evt.size(), exp_evt.size());
        for (int k = 0; k < exp_evt.size() && k < got_evt.size(); k++)
            check($sformatf("%s_evt%0d", name, k), got_evt[k], exp_evt[k]);
        check($sformatf("%s_nbytes", name), got_data.size(), exp_data.size());
        for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
            check($sformatf("%s_data%0d", name, k), got_data[k], exp_data[k]);
            check($sformatf("%s_last%0d", name, k), got_last[k], exp_last[k]);
            check($sformatf("%s_len%0d", name, k), got_len[k], exp_len[k]);
        end
        if (timing && got_evt_cyc.size() > 0 && got_cyc.size() > 0) begin
            check($sformatf("%s_first_latency", name), got_cyc[0], got_evt_cyc[0]);
            for (int k = 1; k < got_cyc.size(); k++)
                check($sformatf("%s_consecutive%0d", name, k), got_cyc[k], got_cyc[k-1] + 1);
        end
        stim_q.delete(); exp_evt.delete(); got_evt.delete(); got_evt_cyc.delete();
        exp_data.delete(); got_data.delete(); exp_last.delete(); got_last.delete();
        exp_len.delete(); got_len.delete(); got_cyc.delete();
    endtask

    task automatic monitor_loop();
        logic       stall;
        logic [7:0] pd;
        logic       pl;
        logic [4:0] pn;
        int         npulse;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                npulse = int'(frame_ok) + int'(err_len) + int'(err_chk) + int'(err_timeout);
                if (frame_ok)    begin got_evt.push_back(EV_OK); got_evt_cyc.push_back(cyc); end
                if (err_len)     got_evt.push_back(EV_LEN);
                if (err_chk)     got_evt.push_back(EV_CHK);
                if (err_timeout) got_evt.push_back(EV_TMO);
                if (npulse > 0) check("pulse_exclusive", npulse, 1);
                if (stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, pd);
                    check("hold_last", out_last, pl);
                    check("hold_len", out_len, pn);
                end
                if (out_valid) begin
                    check("in_ready_in_drain", in_ready, 0);
                    if (out_ready) begin
                        got_data.push_back(out_data);
                        got_last.push_back(out_last);
                        got_len.push_back(int'(out_len));
                        got_cyc.push_back(cyc);
                    end
                end
                stall = out_valid && !out_ready;
                pd = out_data;
                pl = out_last;
                pn = out_len;
            end else begin
                stall = 1'b0;
            end
        end
    endtask

    task automatic ready_loop();
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
                default: out_ready = 1'b0;
            endcase
        end
    endtask

    task automatic pulse_reset(input string name);
        rst_n = 1'b0;
        #1;
        check($sformatf("%s_in_ready_low", name), in_ready, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check($sformatf("%s_outputs_zero", name), outs_vec(), 0);
    endtask

    initial begin
        int first;
        tests = 0; failed = 0; cyc = 0; rdy_mode = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        fork
            monitor_loop();
            ready_loop();
        join_none

        tbl[0] = '{192'hA5_03_11_22_33_03, 6, EV_OK, 128'h11_22_33, 3, 0};
        tbl[1] = '{192'hA5_02_10_20_31, 5, EV_CHK, 128'h0, 0, 0};
        tbl[2] = '{192'hA5_01_7E_7F, 4, EV_OK, 128'h7E, 1, 0};
        tbl[3] = '{192'hA5_00, 2, EV_LEN, 128'h0, 0, 0};
        tbl[4] = '{192'hA5_11, 2, EV_LEN, 128'h0, 0, 0};
        tbl[5] = '{192'h00_FF_55_A5_01_A5_A4, 7, EV_OK, 128'hA5, 1, 0};
        tbl[6] = '{192'hA5_10_00_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10, 19, EV_OK,
                   128'h00_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F, 16, 0};
        tbl[7] = '{192'hA5_03_11_22_33_03, 6, EV_OK, 128'h11_22_33, 3, 2};

        repeat (3) tick();
        check("reset_in_ready", in_ready, 0);
        check("reset_outputs", outs_vec(), 0);
        rst_n = 1'b1;
        #1;
        check("hunt_in_ready", in_ready, 1);
        tick();

        for (int t = 0; t < 8; t++) begin
            rdy_mode = tbl[t].mode;
            for (int k = 0; k < tbl[t].nb; k++)
                stim_q.push_back(tbl[t].bytes[8*(tbl[t].nb-1-k) +: 8]);
            exp_evt.push_back(tbl[t].ev);
            for (int k = 0; k < tbl[t].np; k++) begin
                exp_data.push_back(tbl[t].pay[8*(tbl[t].np-1-k) +: 8]);
                exp_last.push_back(k == tbl[t].np - 1);
                exp_len.push_back(tbl[t].np);
            end
            drive_stim(0);
            settle();
            compare($sformatf("vec%0d", t), tbl[t].mode == 0);
        end

        // Idle after a partial frame: the pulse lands T+1 cycles after the last accept
        rdy_mode = 0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        first = 0;
        for (int k = 1; k <= T + 5; k++) begin
            @(negedge clk);
            if (err_timeout && first == 0) first = k;
        end
        tick();
        check("timeout_cycle", first, T + 1);
        exp_evt.push_back(EV_TMO);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        expect_ok('{8'h7E});
        settle();
        compare("timeout", 1'b0);

        // Byte presented in the expiry cycle wins
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        repeat (T - 1) tick();
        send_byte(8'h22); send_byte(8'h31);
        expect_ok('{8'h11, 8'h22});
        settle();
        compare("expiry_byte", 1'b0);

        // Reset while in PAYLOAD
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        pulse_reset("rst_payload");
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        expect_ok('{8'h7E});
        settle();
        compare("rst_payload", 1'b0);

        // Reset while in DRAIN with the consumer stalled
        rdy_mode = 3;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h55); send_byte(8'h66); send_byte(8'h31);
        check("drain_valid", out_valid, 1);
        check("drain_data", out_data, 8'h55);
        check("drain_len", out_len, 5'd2);
        exp_evt.push_back(EV_OK);
        tick();
        pulse_reset("rst_drain");
        rdy_mode = 0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        expect_ok('{8'h7E});
        settle();
        compare("rst_drain", 1'b0);

        rdy_mode = 1;
        for (int s = 0; s < 40; s++) begin
            gen_stream();
            model_stream();
            drive_stim(3);
            settle();
            compare($sformatf("rnd%0d", s), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
